// File: rtl/bin_shift_sequencer.sv
// Pitch-shift resampling sequencer: walks output bins k = 0..N-1, reads the
// source bin round(k * inv_ratio) from RAM A and writes it (or zero when out of
// range) into RAM C. Arbitrates RAM C's port against the IFFT read side.
module bin_shift_sequencer #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 36,
    parameter int RATIO_W = 16,
    parameter int FRAC    = 12
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              start_i,
    input  logic [RATIO_W-1:0] inv_ratio_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] src_addr_o,
    input  logic [DATA_W-1:0] src_data_i,
    output logic [ADDR_W-1:0] dst_addr_o,
    output logic [DATA_W-1:0] dst_data_o,
    output logic              dst_we_o,
    input  logic [ADDR_W-1:0] ifft_raddr_i,
    output logic              ifft_grant_o
);

    localparam int N  = 1 << ADDR_W;
    // One spare bit so the rounding add can never overflow the product width.
    localparam int PW = ADDR_W + RATIO_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   k_q;          // next bin to issue while in RUN
    logic [RATIO_W-1:0]  ratio_q;
    logic                busy_q, done_q;
    logic [ADDR_W-1:0]   src_addr_q;
    logic [ADDR_W-1:0]   k_d1_q, k_d2_q;
    logic                oob_d1_q, oob_d2_q;
    logic                vld_d1_q, vld_d2_q;
    logic [ADDR_W-1:0]   dst_addr_q;
    logic [DATA_W-1:0]   dst_data_q;
    logic                dst_we_q;

    logic                issue_d;
    logic [ADDR_W-1:0]   k_iss_d;
    logic [RATIO_W-1:0]  r_iss_d;
    logic [PW-1:0]       prod_d, rnd_d, s_d;
    logic                oob_d;

    // S0 address generation; bin 0 issues in the start cycle itself, using the
    // incoming ratio directly since ratio_q is only loaded on that same edge.
    always_comb begin
        issue_d = ((state_q == IDLE) && start_i) || (state_q == RUN);
        k_iss_d = (state_q == IDLE) ? '0 : k_q;
        r_iss_d = (state_q == IDLE) ? inv_ratio_i : ratio_q;
        prod_d  = PW'(k_iss_d) * PW'(r_iss_d);
        rnd_d   = prod_d + PW'(1 << (FRAC - 1));
        s_d     = rnd_d >> FRAC;
        oob_d   = (s_d >= PW'(N)) || (r_iss_d == '0);
    end

    // Control FSM plus the three-stage read/write pipeline, all registered.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            k_q        <= '0;
            ratio_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            src_addr_q <= '0;
            k_d1_q     <= '0;
            k_d2_q     <= '0;
            oob_d1_q   <= 1'b0;
            oob_d2_q   <= 1'b0;
            vld_d1_q   <= 1'b0;
            vld_d2_q   <= 1'b0;
            dst_addr_q <= '0;
            dst_data_q <= '0;
            dst_we_q   <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            vld_d1_q <= issue_d;
            vld_d2_q <= vld_d1_q;
            dst_we_q <= vld_d2_q;
            k_d2_q   <= k_d1_q;
            oob_d2_q <= oob_d1_q;
            // src_addr only moves on issue so it holds its last value when idle.
            if (issue_d) begin
                src_addr_q <= s_d[ADDR_W-1:0];
                k_d1_q     <= k_iss_d;
                oob_d1_q   <= oob_d;
            end
            if (vld_d2_q) begin
                dst_addr_q <= k_d2_q;
                dst_data_q <= oob_d2_q ? '0 : src_data_i;
            end
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        ratio_q <= inv_ratio_i;
                        k_q     <= ADDR_W'(1);
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (k_q == {ADDR_W{1'b1}}) begin
                        k_q     <= '0;
                        state_q <= DRAIN;
                    end else begin
                        k_q <= k_q + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    // The last write is on the port this cycle once both
                    // upstream stages are empty.
                    if (!vld_d1_q && !vld_d2_q) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign src_addr_o   = src_addr_q;
    assign dst_data_o   = dst_data_q;
    assign dst_we_o     = dst_we_q;
    assign dst_addr_o   = busy_q ? dst_addr_q : ifft_raddr_i;
    assign ifft_grant_o = !busy_q;

endmodule

// File: tb/tb_bin_shift_sequencer.sv
// Directed bench for bin_shift_sequencer: table of per-bin expectations plus
// hand-written multi-cycle sequences for restart, arbitration and reset.
module tb_bin_shift_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] inv_ratio;
    logic        busy, done, dst_we, ifft_grant;
    logic [8:0]  src_addr, dst_addr, ifft_raddr;
    logic [35:0] src_data, dst_data;

    int errors = 0;
    int checks = 0;
    logic [35:0] ramc [512];

    typedef struct {
        logic [15:0] ratio;
        int          k;
        int          src;
        bit          zero;
    } vec_t;
    vec_t vecs [15];

    bin_shift_sequencer dut (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .inv_ratio_i(inv_ratio),
        .busy_o(busy), .done_o(done), .src_addr_o(src_addr), .src_data_i(src_data),
        .dst_addr_o(dst_addr), .dst_data_o(dst_data), .dst_we_o(dst_we),
        .ifft_raddr_i(ifft_raddr), .ifft_grant_o(ifft_grant)
    );

    always #5 clk = ~clk;

    function automatic logic [35:0] a_of(input int i);
        logic [17:0] re, im;
        re = 18'(i ^ 'h155);
        im = 18'(i);
        return {re, im};
    endfunction

    // RAM A: registered read, data one cycle after address.
    always_ff @(posedge clk) src_data <= a_of(int'(src_addr));

    function automatic logic [35:0] exp_c(input logic [15:0] r, input int k);
        longint s;
        s = (longint'(k) * longint'(r) + 2048) >>> 12;
        if (r == 16'h0 || s >= 512) return 36'h0;
        return a_of(int'(s));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One pass: start in the current cycle, follow it to done (or a bound),
    // and leave the bench sitting in the done cycle so a following call
    // exercises a start coincident with done.
    task automatic run_pass(input logic [15:0] r, input int restart_cyc);
        int cyc, nw, first, last, dcyc, bad;
        bit asc, busy1, grant1, busy_at_done;
        inv_ratio = r;
        start = 1'b1;
        tick();
        start = 1'b0;
        inv_ratio = 16'h0123;
        cyc = 1; nw = 0; first = -1; last = -1; dcyc = -1; asc = 1'b1;
        busy1 = 1'b0; grant1 = 1'b1; busy_at_done = 1'b1;
        forever begin
            if (cyc == 1) begin busy1 = busy; grant1 = ifft_grant; end
            if (dst_we) begin
                if (first < 0) first = cyc;
                if (int'(dst_addr) != nw) asc = 1'b0;
                ramc[dst_addr] = dst_data;
                nw++;
                last = cyc;
            end
            if (done) begin dcyc = cyc; busy_at_done = busy; break; end
            if (cyc >= 600) break;
            start = (cyc == restart_cyc);
            if (cyc == restart_cyc) inv_ratio = 16'h2000;
            tick();
            cyc++;
        end
        start = 1'b0;
        chk($sformatf("busy_c1 r=%h", r), 64'(busy1), 64'd1);
        chk($sformatf("grant_c1 r=%h", r), 64'(grant1), 64'd0);
        chk($sformatf("first_we r=%h", r), 64'(first), 64'd3);
        chk($sformatf("last_we r=%h", r), 64'(last), 64'd514);
        chk($sformatf("nwrites r=%h", r), 64'(nw), 64'd512);
        chk($sformatf("ascending r=%h", r), 64'(asc), 64'd1);
        chk($sformatf("done_cyc r=%h", r), 64'(dcyc), 64'd515);
        chk($sformatf("busy_at_done r=%h", r), 64'(busy_at_done), 64'd0);
        bad = 0;
        for (int k = 0; k < 512; k++) if (ramc[k] !== exp_c(r, k)) bad++;
        chk($sformatf("ramc_model_mism r=%h", r), 64'(bad), 64'd0);
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].ratio == r) begin
                chk($sformatf("vec%0d r=%h k=%0d", i, r, vecs[i].k), 64'(ramc[vecs[i].k]),
                    vecs[i].zero ? 64'd0 : 64'(a_of(vecs[i].src)));
            end
        end
    endtask

    initial begin
        int ndone;
        vecs[0]  = '{16'h1000, 0,   0,   1'b0};
        vecs[1]  = '{16'h1000, 511, 511, 1'b0};
        vecs[2]  = '{16'h0800, 3,   2,   1'b0};
        vecs[3]  = '{16'h0800, 4,   2,   1'b0};
        vecs[4]  = '{16'h0800, 511, 256, 1'b0};
        vecs[5]  = '{16'h2000, 255, 510, 1'b0};
        vecs[6]  = '{16'h2000, 256, 0,   1'b1};
        vecs[7]  = '{16'h2000, 511, 0,   1'b1};
        vecs[8]  = '{16'h1800, 1,   2,   1'b0};
        vecs[9]  = '{16'h1800, 340, 510, 1'b0};
        vecs[10] = '{16'h1800, 341, 0,   1'b1};
        vecs[11] = '{16'h1800, 0,   0,   1'b0};
        vecs[12] = '{16'h0000, 0,   0,   1'b1};
        vecs[13] = '{16'h0000, 300, 0,   1'b1};
        vecs[14] = '{16'h0000, 511, 0,   1'b1};
        for (int k = 0; k < 512; k++) ramc[k] = 36'hF_FFFF_FFFF;

        reset_n = 1'b0; start = 1'b0; inv_ratio = 16'h0; ifft_raddr = 9'h1A5;
        tick(); tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_we", 64'(dst_we), 64'd0);
        chk("rst_src_addr", 64'(src_addr), 64'd0);
        chk("rst_dst_data", 64'(dst_data), 64'd0);
        chk("rst_grant", 64'(ifft_grant), 64'd1);
        reset_n = 1'b1;
        tick();
        chk("idle_dst_addr", 64'(dst_addr), 64'h1A5);
        ifft_raddr = 9'h05A;
        #1;
        chk("idle_dst_addr_comb", 64'(dst_addr), 64'h05A);
        ifft_raddr = 9'h1A5;

        // Back-to-back passes: each later call starts in the previous done cycle.
        run_pass(16'h1000, -1);
        run_pass(16'h0800, -1);
        run_pass(16'h2000, -1);
        run_pass(16'h1800, -1);
        run_pass(16'h0000, -1);
        tick();
        chk("done_single_pulse", 64'(done), 64'd0);
        chk("idle_grant", 64'(ifft_grant), 64'd1);
        chk("idle_mux", 64'(dst_addr), 64'h1A5);
        tick();

        // Start during a pass (with a ratio change) must be ignored.
        run_pass(16'h1000, 100);
        tick();

        // Reset for one cycle in mid-run; no done may follow.
        inv_ratio = 16'h1000; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (100) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_we", 64'(dst_we), 64'd0);
        chk("midrst_grant", 64'(ifft_grant), 64'd1);
        ndone = 0;
        for (int c = 0; c < 600; c++) begin
            if (done || dst_we) ndone++;
            tick();
        end
        chk("midrst_no_done_or_we", 64'(ndone), 64'd0);
        run_pass(16'h0800, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
